freq_div_prog: RTL

//  Run-time programmable clock divider with display scan counter. Generates a 50%-duty

---
 rtl/freq_div_prog.sv | 131 +++++++++++++
 1 files changed

// File: rtl/freq_div_prog.sv
// ---------------------------------------------------------------------------
// freq_div_prog
//
// Run-time programmable clock divider with a free-running display scan
// counter. Produces a registered 50%-duty divided clock (clk_out) whose
// half-period is term+1 clk cycles. A new terminal count can be loaded at
// any time. It only takes effect at a terminal count, so clk_out never
// glitches or produces a short phase.
//
// Optional feature macro: FREQ_DIV_TICK_EN
//   defined   : tick pulses for one cycle each time clk_out has just risen
//   undefined : tick is tied to 0 and its register is not built
//
// Parameters
//   CNT_W        width of the divider counter and of div_val
//   DIV_DEFAULT  half-period terminal count loaded at reset
//   SCAN_W       width of clk_ssd (2**SCAN_W display digits)
//   SCAN_SHIFT   clk_ssd advances once every 2**SCAN_SHIFT clk cycles
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   en         in   1: divider counts, 0: divider and clk_out hold
//   div_load   in   one-cycle strobe that captures div_val
//   div_val    in   new terminal count (half-period = div_val+1 cycles)
//   load_pend  out  a captured divisor is waiting for the next terminal
//   clk_out    out  divided clock, registered
//   tick       out  one-cycle pulse on each clk_out 0->1
//   clk_ssd    out  display scan select, free-running
//
// Load interface: div_load is a fire-and-forget strobe with no ready.
// Every cycle with div_load=1 is accepted. If several loads arrive before a
// terminal count, the last one wins. load_pend reports that a value is
// parked and not yet applied.
// ---------------------------------------------------------------------------
module freq_div_prog #(
    parameter int unsigned          CNT_W       = 26,
    parameter logic [CNT_W-1:0]     DIV_DEFAULT = CNT_W'(49_999_999),
    parameter int unsigned          SCAN_W      = 2,
    parameter int unsigned          SCAN_SHIFT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              div_load,
    input  logic [CNT_W-1:0]  div_val,
    output logic              load_pend,
    output logic              clk_out,
    output logic              tick,
    output logic [SCAN_W-1:0] clk_ssd
);

    localparam int unsigned SC_W = SCAN_W + SCAN_SHIFT;

    logic [CNT_W-1:0] q;
    logic [CNT_W-1:0] term;
    logic [CNT_W-1:0] pending;
    logic             pend_r;
    logic             clk_out_r;
    logic [SC_W-1:0]  scan;
    logic             terminal;

    // The terminal count only counts while enabled. A paused divider never
    // toggles and never applies a parked divisor.
    assign terminal = en && (q == term);

    // Divider counter, divided clock and divisor update
    always_ff @(posedge clk) begin
        if (reset) begin
            q         <= '0;
            clk_out_r <= 1'b0;
            term      <= DIV_DEFAULT;
            pending   <= '0;
            pend_r    <= 1'b0;
        end else if (terminal) begin
            q         <= '0;
            clk_out_r <= ~clk_out_r;
            // A load landing on the terminal cycle takes priority over a
            // parked value, so it applies immediately rather than one
            // half-period later.
            if (div_load) begin
                term <= div_val;
            end else if (pend_r) begin
                term <= pending;
            end
            pend_r    <= 1'b0;
        end else begin
            if (en) begin
                q <= q + CNT_W'(1);
            end
            if (div_load) begin
                pending <= div_val;
                pend_r  <= 1'b1;
            end
        end
    end

    // Scan counter runs regardless of en so the display keeps refreshing
    // while the divider is paused.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan <= '0;
        end else begin
            scan <= scan + SC_W'(1);
        end
    end

`ifdef FREQ_DIV_TICK_EN
    logic tick_r;

    // The rising edge of clk_out happens on a terminal cycle while clk_out
    // is still low. Registering that condition aligns tick with the first
    // high cycle of clk_out.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_r <= 1'b0;
        end else begin
            tick_r <= terminal && !clk_out_r;
        end
    end

    assign tick = tick_r;
`else
    assign tick = 1'b0;
`endif

    assign load_pend = pend_r;
    assign clk_out   = clk_out_r;
    assign clk_ssd   = scan[SC_W-1 -: SCAN_W];

endmodule
